// File: rtl/jk_mod_counter.sv
// Up/down modulo-N counter built on a bank of JK flip-flops.
// The next count is computed from the current state and the controls. The per-bit J/K
// excitation that moves the bank to that count is then derived from it. The bank applies
// that excitation at the rising edge, and its q/qnot outputs feed back into the
// next-state logic.
module jk_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             tc,
  output logic             wrap
);

  // Largest legal count. MODULUS is at most 2**WIDTH, so this always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] OneVal = WIDTH'(1);
  // When the modulus spans every code, natural WIDTH-bit wrap-around gives the right answer.
  localparam bit FullRange = (MODULUS == (2 ** WIDTH));

  // Feedback from the flip-flop bank.
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qnot;

  // Decoded state and next-state.
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_load_over;
  logic [WIDTH-1:0] w_load_sat;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_tc;

  // Wrap pulse register.
  logic             r_wrap;

  // Terminal-state decodes and the clamped load value.
  always_comb begin
    w_at_max    = (w_q == MaxVal);
    w_at_zero   = (w_q == '0);
    w_load_over = FullRange ? 1'b0 : (load_val > MaxVal);
    w_load_sat  = w_load_over ? MaxVal : load_val;
  end

  // Next count: load beats count, count beats hold.
  always_comb begin
    w_nxt = w_q;
    if (load) begin
      w_nxt = w_load_sat;
    end else if (en && up) begin
      if (FullRange) begin
        w_nxt = w_q + OneVal;
      end else begin
        w_nxt = w_at_max ? '0 : (w_q + OneVal);
      end
    end else if (en) begin
      if (FullRange) begin
        w_nxt = w_q - OneVal;
      end else begin
        w_nxt = w_at_zero ? MaxVal : (w_q - OneVal);
      end
    end
  end

  // JK excitation: set the bits that rise and clear the bits that fall. Toggle is never
  // issued, and hold leaves both J and K low.
  always_comb begin
    w_j = w_qnot & w_nxt;
    w_k = w_q & ~w_nxt;
  end

  // Terminal count is asserted in the cycle before a counting wrap edge. It is masked
  // while a load is pending.
  always_comb begin
    w_tc = en & ~load & ((up & w_at_max) | (~up & w_at_zero));
  end

  // JK flip-flop bank, one flop per bit, cleared asynchronously.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_bank
    logic r_bit;

    // Standard JK update at the rising edge.
    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        r_bit <= 1'b0;
      end else begin
        unique case ({w_j[gi], w_k[gi]})
          2'b10:   r_bit <= 1'b1;
          2'b01:   r_bit <= 1'b0;
          2'b11:   r_bit <= ~r_bit;
          default: r_bit <= r_bit;
        endcase
      end
    end

    assign w_q[gi]    = r_bit;
    assign w_qnot[gi] = ~r_bit;
  end

  // Wrap marks the cycle that follows a wrap edge.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tc;
    end
  end

  assign q     = w_q;
  assign qnot  = w_qnot;
  assign j_out = w_j;
  assign k_out = w_k;
  assign tc    = w_tc;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboarded bench for jk_mod_counter: a mod-10 instance (WIDTH=4) and a full-range
// mod-8 instance (WIDTH=3) share stimulus. Each directed row drives the inputs for one
// cycle and queues the hand-computed values expected in that cycle. The monitor pops
// one row per cycle, samples the outputs away from the rising edge, and compares them.
module tb_jk_mod_counter;

  typedef struct packed {
    int unsigned row;
    bit          sel;    // 0: mod-10 instance, 1: mod-8 instance
    logic [3:0]  q;
    logic [3:0]  j;
    logic [3:0]  k;
    logic        tc;
    logic        wrap;
  } exp_t;

  logic       clk;
  logic       clear_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] q10, qnot10, j10, k10;
  logic       tc10, wrap10;
  logic [2:0] q8, qnot8, j8, k8;
  logic       tc8, wrap8;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_num  = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk      (clk),
    .clear_n  (clear_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q10),
    .qnot     (qnot10),
    .j_out    (j10),
    .k_out    (k10),
    .tc       (tc10),
    .wrap     (wrap10)
  );

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut8 (
    .clk      (clk),
    .clear_n  (clear_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val[2:0]),
    .q        (q8),
    .qnot     (qnot8),
    .j_out    (j8),
    .k_out    (k8),
    .tc       (tc8),
    .wrap     (wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int unsigned row, input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %b, expected %b", row, name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled 2 time units after the falling edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.sel) begin
        chk(e.row, "q", q10, e.q);
        chk(e.row, "qnot", qnot10, ~e.q);
        chk(e.row, "j_out", j10, e.j);
        chk(e.row, "k_out", k10, e.k);
        chk(e.row, "tc", {3'b000, tc10}, {3'b000, e.tc});
        chk(e.row, "wrap", {3'b000, wrap10}, {3'b000, e.wrap});
      end else begin
        chk(e.row, "q8", {1'b0, q8}, e.q);
        chk(e.row, "qnot8", {1'b0, qnot8}, {1'b0, ~e.q[2:0]});
        chk(e.row, "j_out8", {1'b0, j8}, e.j);
        chk(e.row, "k_out8", {1'b0, k8}, e.k);
        chk(e.row, "tc8", {3'b000, tc8}, {3'b000, e.tc});
        chk(e.row, "wrap8", {3'b000, wrap8}, {3'b000, e.wrap});
      end
    end
  end

  // Drive one cycle of stimulus at the falling edge and queue what that cycle must show.
  task automatic row(input logic c_n, input logic e_i, input logic u_i, input logic l_i,
                     input logic [3:0] lv, input bit sel, input logic [3:0] xq,
                     input logic [3:0] xj, input logic [3:0] xk, input logic xtc,
                     input logic xw);
    exp_t e;
    @(negedge clk);
    clear_n  = c_n;
    en       = e_i;
    up       = u_i;
    load     = l_i;
    load_val = lv;
    e.row  = row_num;
    e.sel  = sel;
    e.q    = xq;
    e.j    = xj;
    e.k    = xk;
    e.tc   = xtc;
    e.wrap = xw;
    sb.push_back(e);
    row_num++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_n  = 1'b0;
    en       = 1'b0;
    up       = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;

    //   clr en up ld lv     sel q      j        k        tc wrap
    // Reset held for two cycles.
    row(0, 0, 0, 0, 4'd0,  0, 4'd0, 4'b0000, 4'b0000, 0, 0);
    row(0, 0, 0, 0, 4'd0,  0, 4'd0, 4'b0000, 4'b0000, 0, 0);
    // Count up for 12 edges through the 9 -> 0 wrap.
    row(1, 1, 1, 0, 4'd0,  0, 4'd0, 4'b0001, 4'b0000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd1, 4'b0010, 4'b0001, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd2, 4'b0001, 4'b0000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd3, 4'b0100, 4'b0011, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd4, 4'b0001, 4'b0000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd5, 4'b0010, 4'b0001, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd6, 4'b0001, 4'b0000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd7, 4'b1000, 4'b0111, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd8, 4'b0001, 4'b0000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd9, 4'b0000, 4'b1001, 1, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd0, 4'b0001, 4'b0000, 0, 1);
    row(1, 1, 1, 0, 4'd0,  0, 4'd1, 4'b0010, 4'b0001, 0, 0);
    // Load 0, then count down through the 0 -> 9 wrap.
    row(1, 0, 0, 1, 4'd0,  0, 4'd2, 4'b0000, 4'b0010, 0, 0);
    row(1, 1, 0, 0, 4'd0,  0, 4'd0, 4'b1001, 4'b0000, 1, 0);
    row(1, 1, 0, 0, 4'd0,  0, 4'd9, 4'b0000, 4'b0001, 0, 1);
    row(1, 1, 0, 0, 4'd0,  0, 4'd8, 4'b0111, 4'b1000, 0, 0);
    // Load priority and clamping.
    row(1, 0, 0, 1, 4'd5,  0, 4'd7, 4'b0000, 4'b0010, 0, 0);
    row(1, 1, 1, 1, 4'd13, 0, 4'd5, 4'b1000, 4'b0100, 0, 0);
    row(1, 1, 1, 1, 4'd3,  0, 4'd9, 4'b0010, 4'b1000, 0, 0);
    // Excitation at 7, hold with en low.
    row(1, 0, 0, 1, 4'd7,  0, 4'd3, 4'b0100, 4'b0000, 0, 0);
    row(1, 0, 1, 0, 4'd0,  0, 4'd7, 4'b0000, 4'b0000, 0, 0);
    row(1, 0, 1, 0, 4'd0,  0, 4'd7, 4'b0000, 4'b0000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd7, 4'b1000, 4'b0111, 0, 0);
    row(1, 0, 1, 0, 4'd0,  0, 4'd8, 4'b0000, 4'b0000, 0, 0);
    // At 9, counting down is not terminal.
    row(1, 0, 0, 1, 4'd9,  0, 4'd8, 4'b0001, 4'b0000, 0, 0);
    row(1, 1, 0, 0, 4'd0,  0, 4'd9, 4'b0000, 4'b0001, 0, 0);
    // Reach 6, then clear asynchronously between edges.
    row(1, 0, 0, 1, 4'd5,  0, 4'd8, 4'b0101, 4'b1000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd5, 4'b0010, 4'b0001, 0, 0);
    row(1, 0, 1, 0, 4'd0,  0, 4'd6, 4'b0000, 4'b0000, 0, 0);
    row(0, 0, 1, 0, 4'd0,  0, 4'd0, 4'b0000, 4'b0000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd0, 4'b0001, 4'b0000, 0, 0);
    row(1, 0, 1, 0, 4'd0,  0, 4'd1, 4'b0000, 4'b0000, 0, 0);
    // Clear right after a wrap edge kills the wrap pulse.
    row(1, 0, 0, 1, 4'd9,  0, 4'd1, 4'b1000, 4'b0000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  0, 4'd9, 4'b0000, 4'b1001, 1, 0);
    row(0, 0, 1, 0, 4'd0,  0, 4'd0, 4'b0000, 4'b0000, 0, 0);
    row(1, 0, 1, 0, 4'd0,  0, 4'd0, 4'b0000, 4'b0000, 0, 0);
    // Full-range mod-8 instance: natural wraps and an unclamped load of 7.
    row(1, 1, 0, 0, 4'd0,  1, 4'd0, 4'b0111, 4'b0000, 1, 0);
    row(1, 0, 0, 0, 4'd0,  1, 4'd7, 4'b0000, 4'b0000, 0, 1);
    row(1, 0, 0, 1, 4'd7,  1, 4'd7, 4'b0000, 4'b0000, 0, 0);
    row(1, 1, 1, 0, 4'd0,  1, 4'd7, 4'b0000, 4'b0111, 1, 0);
    row(1, 0, 1, 0, 4'd0,  1, 4'd0, 4'b0000, 4'b0000, 0, 1);
    row(1, 0, 1, 1, 4'd7,  1, 4'd0, 4'b0111, 4'b0000, 0, 0);
    row(1, 0, 1, 0, 4'd0,  1, 4'd7, 4'b0000, 4'b0000, 0, 0);

    // Let the monitor drain the last entry.
    repeat (3) @(negedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
